// File: rtl/bitstream_counter.sv
// Stochastic-to-binary converter: counts the ones of a bitstream over a fixed
// WINDOW-cycle window and presents the total with a one-cycle valid strobe.
module bitstream_counter #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned WIDTH  = 9
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             x,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned CntW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WINDOW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  acc_inc;

    // The final sample is folded into the result directly, so the last cycle
    // of the window never needs to be written back to the accumulator first.
    assign acc_inc = acc_q + WIDTH'(x);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCount;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            StCount: begin
                cnt_d = cnt_q + CntW'(1);
                acc_d = acc_inc;
                if (cnt_q == CntLast) begin
                    y_d     = acc_inc;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StCount;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    assign y     = y_q;
    assign valid = (state_q == StDone);
    assign busy  = (state_q == StCount);

endmodule

// File: tb/tb_bitstream_counter.sv
// Directed bench for bitstream_counter: expected counts are queued as each
// window is driven and popped when the valid strobe arrives.
module tb_bitstream_counter;

    localparam int unsigned WINDOW = 256;
    localparam int unsigned WIDTH  = 9;

    logic             clk   = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic             x     = 1'b0;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             busy;

    int        n_pass  = 0;
    int        n_total = 0;
    int        exp_q[$];
    int        last_exp = 0;
    logic [7:0] lfsr    = 8'hA5;

    bitstream_counter #(
        .WINDOW(WINDOW),
        .WIDTH (WIDTH)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .start(start),
        .x    (x),
        .y    (y),
        .valid(valid),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // mode 0: all zeros, 1: all ones, 2: 1,0,1,0..., 3: generator with x=64
    task automatic conv(input int mode, input bit chained, input bit mid_start,
                        input int fixed_exp, input string tag);
        int               cnt1      = 0;
        int               busy_cnt  = 0;
        int               valid_in  = 0;
        int               y_changes = 0;
        int               lat;
        int               e;
        logic             xv;
        logic [WIDTH-1:0] y_hold;
        if (!chained) begin
            step();
            start = 1'b1;
        end
        step();
        start  = 1'b0;
        lat    = 1;
        y_hold = y;
        for (int i = 0; i < int'(WINDOW); i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (valid === 1'b1) valid_in++;
            if (y !== y_hold) y_changes++;
            case (mode)
                0: xv = 1'b0;
                1: xv = 1'b1;
                2: xv = (i % 2 == 0);
                3: begin
                    xv   = (lfsr < 8'd64);
                    lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                end
                default: xv = 1'b0;
            endcase
            x = xv;
            cnt1 += int'(xv);
            if (mid_start && i >= 100) start = 1'b1;
            step();
            lat++;
        end
        exp_q.push_back((fixed_exp >= 0) ? fixed_exp : cnt1);
        while (valid !== 1'b1 && lat < int'(WINDOW) + 20) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, WINDOW + 1);
        chk({tag, " busy cycles"}, busy_cnt, WINDOW);
        chk({tag, " valid during count"}, valid_in, 0);
        chk({tag, " y held during count"}, y_changes, 0);
        chk({tag, " busy with valid"}, busy, 1'b0);
        e        = exp_q.pop_front();
        last_exp = e;
        chk({tag, " y"}, y, e);
        if (!mid_start) begin
            step();
            chk({tag, " valid one cycle"}, valid, 1'b0);
            chk({tag, " y held after"}, y, last_exp);
        end
    endtask

    initial begin
        int idle_busy;
        int idle_valid;

        n_rst = 1'b0;
        start = 1'b1;
        step();
        step();
        chk("reset y", y, 0);
        chk("reset valid", valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        n_rst = 1'b1;
        start = 1'b0;
        step();

        conv(0, 1'b0, 1'b0, 0, "zeros");
        conv(1, 1'b0, 1'b0, 256, "ones");
        conv(0, 1'b0, 1'b0, 0, "zeros again");
        conv(2, 1'b0, 1'b0, 128, "toggle");
        conv(3, 1'b0, 1'b0, -1, "generator");

        // Start raised mid-window and held through DONE: second window chains.
        conv(3, 1'b0, 1'b1, -1, "mid start");
        conv(1, 1'b1, 1'b0, 256, "chained");

        // Reset at COUNT cycle 100 with start high.
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            x = 1'b1;
            step();
        end
        chk("pre-reset busy", busy, 1'b1);
        n_rst = 1'b0;
        start = 1'b1;
        step();
        chk("mid reset y", y, 0);
        chk("mid reset valid", valid, 1'b0);
        chk("mid reset busy", busy, 1'b0);
        n_rst = 1'b1;
        start = 1'b0;
        idle_busy  = 0;
        idle_valid = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy === 1'b1) idle_busy++;
            if (valid === 1'b1) idle_valid++;
        end
        chk("post reset idle busy", idle_busy, 0);
        chk("post reset idle valid", idle_valid, 0);

        conv(3, 1'b0, 1'b0, -1, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bitstream_counter.md
# bitstream_counter

Stochastic-to-binary converter that sits directly downstream of the LFSR bitstream generators and the bitstream arithmetic network. On a start request it counts the '1' bits of a single stochastic bitstream over a fixed window of WINDOW clock cycles. It then presents the count as a binary result with a one-cycle valid strobe. The count/WINDOW ratio is the decoded probability, the inverse of what a generator does with its x input.

## Interface
- WINDOW, 256: number of bitstream cycles per conversion; ≥ 2. 256 matches one period-scale of the 8-bit generators.
- WIDTH, 9: result width; must satisfy 2^WIDTH > WINDOW so that an all-ones stream is representable.
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
- start  input  1  conversion request, sampled only in IDLE and DONE.
- x  input  1  stochastic bitstream (a generator y output or a network node).
- y  output  WIDTH  count of ones in the last completed window; held until the next conversion completes.
- valid  output  1  high for exactly one cycle when y is updated.
- busy  output  1  high while a window is being counted (state COUNT).

## Operation
- States: IDLE, COUNT, DONE. An internal window counter `cnt` has width clog2(WINDOW). An internal accumulator `acc` is WIDTH bits.
- IDLE: on start=1, go to COUNT, clear `cnt` and `acc`. Otherwise remain in IDLE.
- COUNT:
  - Each cycle, `acc` ← `acc` + x and `cnt` ← `cnt` + 1.
  - In the cycle where `cnt` = WINDOW−1, the final sample is included: y ← `acc` + x and the state goes to DONE.
  - start is ignored in COUNT.
  - x is sampled in exactly WINDOW consecutive cycles.
- DONE (one cycle):
  - valid=1.
  - If start=1, go directly to COUNT with `cnt` and `acc` cleared (back-to-back conversion, no gap). Otherwise go to IDLE.
- Arithmetic: the accumulator never overflows given the WIDTH rule. The result range is 0..WINDOW inclusive. There is no saturation logic.
- x is used only in COUNT; its value in IDLE and DONE has no effect.
- Reset (n_rst=0 at a clock edge), from any state including mid-COUNT:
  - state=IDLE, `cnt`=0, `acc`=0, y=0, valid=0, busy=0.
  - Any partial count is discarded. start asserted in the same cycle as reset is ignored.
- Outputs are registered or decoded purely from state; there is no combinational path from x or start to any output.

## Timing
- Edge numbering: start=1 is sampled at edge E in IDLE. busy rises after E. x is sampled at edges E+1 … E+WINDOW.
- At edge E+WINDOW, y is updated and the state becomes DONE. valid is high in the cycle after E+WINDOW, for exactly one cycle.
- Latency from start edge to valid: WINDOW+1 cycles.
- Back-to-back throughput: one result per WINDOW+1 cycles.
- busy is high for exactly WINDOW cycles per conversion. busy and valid are never high together.
- y is stable from the valid cycle until the valid cycle of the next conversion. y is not cleared by start.
- Reset values: y=0, valid=0, busy=0, state IDLE. Reset takes effect at the first clk edge with n_rst=0.

## Test plan
- x held 0, one start pulse, WINDOW=256:
  - valid is seen exactly 257 cycles after the start edge.
  - y=0 and busy high for 256 cycles.
- x held 1, one start pulse:
  - y=256 (9'h100), showing the full-scale result with no wrap.
  - A second run with x=0 then gives y=0.
- x toggling 1,0,1,0… from the first COUNT cycle: y=128.
- Generator in the loop: generator x=64 feeding x, 256-cycle window from reset release.
  - y equals the reference-model count of (lfsr < 64) over the same 256 cycles.
- start re-asserted during COUNT, then held high through DONE:
  - The mid-COUNT start is ignored.
  - The second conversion begins at the DONE edge; the two valid pulses are exactly 257 cycles apart.
- n_rst=0 for one cycle at COUNT cycle 100, with start held high:
  - Next cycle: IDLE, y=0, valid=0, busy=0, and no conversion is started.
  - A new start then gives a correct full-window count.
